// File: rtl/vga_sync_rx_if.sv
// vga_sync_rx_if: pixel-stream bundle from the VGA timing generator to the
// sync receiver. The generator drives through master; the receiver samples
// through slave. hs/vs/col are only meaningful on cycles with pix_en_i high.
`timescale 1ns/1ps
interface vga_sync_rx_if;
    logic       pix_en_i;
    logic       hs_i;
    logic       vs_i;
    logic [7:0] col_i;

    modport master (output pix_en_i, hs_i, vs_i, col_i);
    modport slave  (input  pix_en_i, hs_i, vs_i, col_i);
endinterface

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel x/y, data-enable and frame start from the
// registered hs/vs/colour stream and checks it against the configured format.
// Lock is declared after LOCK_FRAMES clean frames and dropped on the first
// timing violation.
// Define VGA_SYNC_RX_STATS_EN to add the h_meas_o/v_meas_o/err_cnt_o outputs.
`timescale 1ns/1ps
module vga_sync_rx #(
    parameter int unsigned H_TOTAL      = 1650,
    parameter int unsigned V_TOTAL      = 750,
    parameter int unsigned H_ACTIVE     = 1280,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned H_SYNC_BEGIN = 1390,
    parameter int unsigned V_SYNC_BEGIN = 725,
    parameter int unsigned LOCK_FRAMES  = 2,
    parameter bit          SYNC_POL     = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vga_sync_rx_if.slave vid,
    output logic [10:0]  x_o,
    output logic [9:0]   y_o,
    output logic         de_o,
    output logic [7:0]   col_o,
    output logic         frame_start_o,
    output logic         locked_o,
    output logic         err_o
`ifdef VGA_SYNC_RX_STATS_EN
    ,
    output logic [10:0]  h_meas_o,
    output logic [9:0]   v_meas_o,
    output logic [7:0]   err_cnt_o
`endif
);
    localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT     = 11'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT     = 10'(V_ACTIVE);
    localparam logic [10:0] X_HS      = 11'(H_SYNC_BEGIN);
    localparam logic [9:0]  Y_VS      = 10'(V_SYNC_BEGIN);
    localparam logic [11:0] GAP_LIMIT = 12'(2 * H_TOTAL);
    localparam logic [3:0]  GOOD_LOCK = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_prev_q, vs_prev_q;
    logic        hs_act, vs_act, hs_edge, vs_edge;
    logic [10:0] x_pred, x_d;
    logic [9:0]  y_pred, y_d;
    logic [11:0] gap_q, gap_inc, gap_d;
    logic [3:0]  good_q, good_d;
    logic        check_fail, err_d, lock_d, de_d, fs_d;

    // Edge detection, counter prediction, timing checks and next state.
    always_comb begin
        hs_act  = (vid.hs_i == SYNC_POL);
        vs_act  = (vid.vs_i == SYNC_POL);
        hs_edge = hs_act && !hs_prev_q;
        vs_edge = vs_act && !vs_prev_q;

        x_pred = (x_o == X_LAST) ? '0 : x_o + 11'd1;
        y_pred = y_o;
        if (x_o == X_LAST) begin
            y_pred = (y_o == Y_LAST) ? '0 : y_o + 10'd1;
        end
        gap_inc = (gap_q == '1) ? gap_q : gap_q + 12'd1;

        check_fail = (hs_edge && (x_pred != X_HS))
                  || (vs_edge && ((x_pred != '0) || (y_pred != Y_VS)))
                  || (!hs_edge && (gap_inc >= GAP_LIMIT));

        state_d = state_q;
        x_d     = x_pred;
        y_d     = y_pred;
        good_d  = good_q;
        gap_d   = hs_edge ? '0 : gap_inc;
        err_d   = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    x_d     = '0;
                    y_d     = Y_VS;
                    good_d  = '0;
                    gap_d   = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (check_fail) begin
                    err_d   = 1'b1;
                    good_d  = '0;
                    gap_d   = '0;
                    state_d = SEARCH;
                    // A failing vs edge still carries a usable frame reference.
                    if (vs_edge) begin
                        x_d     = '0;
                        y_d     = Y_VS;
                        state_d = MEASURE;
                    end
                end else if (vs_edge && (state_q == MEASURE)) begin
                    good_d = good_q + 4'd1;
                    if (good_d >= GOOD_LOCK) state_d = LOCKED;
                end
            end
            default: state_d = SEARCH;
        endcase

        lock_d = (state_d == LOCKED);
        de_d   = lock_d && (x_d < X_ACT) && (y_d < Y_ACT);
        fs_d   = lock_d && (x_d == '0) && (y_d == '0);
    end

    // State, counters and outputs advance on strobes; pulses clear in between.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SEARCH;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            gap_q         <= '0;
            good_q        <= '0;
            x_o           <= '0;
            y_o           <= '0;
            de_o          <= 1'b0;
            col_o         <= '0;
            frame_start_o <= 1'b0;
            locked_o      <= 1'b0;
            err_o         <= 1'b0;
        end else if (vid.pix_en_i) begin
            state_q       <= state_d;
            hs_prev_q     <= hs_act;
            vs_prev_q     <= vs_act;
            gap_q         <= gap_d;
            good_q        <= good_d;
            x_o           <= x_d;
            y_o           <= y_d;
            de_o          <= de_d;
            col_o         <= de_d ? vid.col_i : '0;
            frame_start_o <= fs_d;
            locked_o      <= lock_d;
            err_o         <= err_d;
        end else begin
            frame_start_o <= 1'b0;
            err_o         <= 1'b0;
        end
    end

`ifdef VGA_SYNC_RX_STATS_EN
    logic [10:0] h_cnt_q, h_cnt_inc;
    logic [9:0]  v_cnt_q, v_cnt_inc;

    // Saturating increments for the line-length and lines-per-frame counters.
    always_comb begin
        h_cnt_inc = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 11'd1;
        v_cnt_inc = v_cnt_q;
        if (hs_edge && (v_cnt_q != '1)) v_cnt_inc = v_cnt_q + 10'd1;
    end

    // Measure hs spacing in strobes, vs spacing in hs edges, and count errors.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_meas_o  <= '0;
            v_meas_o  <= '0;
            err_cnt_o <= '0;
        end else if (vid.pix_en_i) begin
            if (hs_edge) begin
                h_meas_o <= h_cnt_inc;
                h_cnt_q  <= '0;
            end else begin
                h_cnt_q  <= h_cnt_inc;
            end
            if (vs_edge) begin
                v_meas_o <= v_cnt_inc;
                v_cnt_q  <= '0;
            end else begin
                v_cnt_q  <= v_cnt_inc;
            end
            if (err_d && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: vector table for short sequences from reset, then a
// randomly strobed generator stream checked against a position-based model,
// with short-line, lost-hs and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_vga_sync_rx;
    localparam int H = 40, V = 12, HA = 24, VA = 8, HSB = 30, VSB = 10, LF = 2;
    localparam int HSW = 4, VSW = 2;
    localparam bit POL = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_sync_rx_if vif();
    logic [10:0] x;
    logic [9:0]  y;
    logic        de, fs, lk, er;
    logic [7:0]  colo;
`ifdef VGA_SYNC_RX_STATS_EN
    logic [10:0] hm;
    logic [9:0]  vm;
    logic [7:0]  ec;
`endif

    vga_sync_rx #(
        .H_TOTAL(H), .V_TOTAL(V), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_SYNC_BEGIN(HSB), .V_SYNC_BEGIN(VSB), .LOCK_FRAMES(LF), .SYNC_POL(POL)
    ) dut (
        .clk_i(clk), .rst_i(rst), .vid(vif),
        .x_o(x), .y_o(y), .de_o(de), .col_o(colo),
        .frame_start_o(fs), .locked_o(lk), .err_o(er)
`ifdef VGA_SYNC_RX_STATS_EN
        , .h_meas_o(hm), .v_meas_o(vm), .err_cnt_o(ec)
`endif
    );

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: linear position within the frame.
    int m_pos, m_sidx, m_ref, m_good;
    bit m_al, m_lk, m_ph, m_pv;
    int e_x, e_y;
    bit e_de, e_fs, e_er;
    logic [7:0] e_col;

    task automatic model_reset();
        m_pos = 0; m_sidx = 0; m_ref = 0; m_good = 0;
        m_al = 0; m_lk = 0; m_ph = 0; m_pv = 0;
        e_x = 0; e_y = 0; e_de = 0; e_fs = 0; e_er = 0; e_col = 8'h00;
    endtask

    task automatic model_strobe(input bit hs, input bit vs, input logic [7:0] c);
        bit ha, va, he, ve, bad;
        ha = (hs == POL); va = (vs == POL);
        he = ha && !m_ph; ve = va && !m_pv;
        m_ph = ha; m_pv = va;
        m_sidx++;
        m_pos = (m_pos + 1) % (H * V);
        e_er = 0;
        if (!m_al) begin
            if (ve) begin m_pos = VSB * H; m_al = 1; m_good = 0; m_ref = m_sidx; end
        end else begin
            bad = (he && (m_pos % H) != HSB) || (ve && m_pos != VSB * H)
               || (!he && (m_sidx - m_ref) >= 2 * H);
            if (bad) begin
                e_er = 1; m_lk = 0; m_good = 0; m_al = 0; m_ref = m_sidx;
                if (ve) begin m_pos = VSB * H; m_al = 1; end
            end else if (ve && !m_lk) begin
                m_good++;
                if (m_good >= LF) m_lk = 1;
            end
        end
        if (he) m_ref = m_sidx;
        e_x = m_pos % H; e_y = m_pos / H;
        e_de = m_lk && e_x < HA && e_y < VA;
        e_col = e_de ? c : 8'h00;
        e_fs = m_lk && m_pos == 0;
    endtask

    // Bench-side tallies of the generated stream.
    bit t_ph, t_pv, t_he, t_ve, fr_valid, lock_pending, lk_prev, kill_active;
    int n_vse, since_hs, de_cnt, st_cnt, n_err;

    task automatic tally_reset();
        t_ph = 0; t_pv = 0; n_vse = 0; since_hs = 0;
        fr_valid = 0; de_cnt = 0; st_cnt = 0;
    endtask

    task automatic step(input bit r, input bit pe, input bit hs, input bit vs, input logic [7:0] c);
        rst = r; vif.pix_en_i = pe; vif.hs_i = hs; vif.vs_i = vs; vif.col_i = c;
        @(posedge clk); #1;
        t_he = 0; t_ve = 0;
        if (r) begin
            model_reset(); tally_reset();
        end else if (pe) begin
            model_strobe(hs, vs, c);
            t_he = (hs == POL) && !t_ph; t_ve = (vs == POL) && !t_pv;
            t_ph = (hs == POL); t_pv = (vs == POL);
            if (t_ve) n_vse++;
            since_hs = t_he ? 0 : since_hs + 1;
        end else begin
            e_fs = 0; e_er = 0;
        end
        check("outputs", 64'({x, y, de, colo, fs, lk, er}),
              64'({11'(e_x), 10'(e_y), e_de, e_col, e_fs, m_lk, e_er}));
        if (er) n_err++;
        if (er && kill_active) check("timeout_gap", 64'(since_hs), 64'(2 * H));
        if (lk && !lk_prev && lock_pending) begin
            check("lock_vs_count", 64'(n_vse), 64'(3));
            check("lock_on_vs_edge", 64'(t_ve), 64'(1));
            lock_pending = 0;
        end
        if (!r && pe) begin
            if (fs) begin
                if (fr_valid) begin
                    check("de_per_frame", 64'(de_cnt), 64'(HA * VA));
                    check("strobes_per_frame", 64'(st_cnt), 64'(H * V));
                end
                fr_valid = 1; de_cnt = 0; st_cnt = 0;
            end
            st_cnt++;
            if (de) begin
                de_cnt++;
                check("col_passthru", 64'(colo), 64'(c));
            end
        end
        if (!lk) fr_valid = 0;
        lk_prev = lk;
    endtask

    // Generator model: column g_c of line g_l, current line length g_len.
    int g_c, g_l, g_len;

    task automatic gen_next(input bit kill, output bit hs, output bit vs);
        hs = (g_c >= HSB && g_c < HSB + HSW && !kill) ? POL : !POL;
        vs = (g_l >= VSB && g_l < VSB + VSW) ? POL : !POL;
        g_c++;
        if (g_c >= g_len) begin g_c = 0; g_l = (g_l + 1) % V; g_len = H; end
    endtask

    task automatic run(input int n, input int kill_n);
        bit hs, vs;
        for (int i = 0; i < n; i++) begin
            int idle;
            idle = int'($urandom_range(0, 6));
            for (int k = 0; k < idle; k++)
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            kill_active = (i < kill_n);
            gen_next(kill_active, hs, vs);
            step(1'b0, 1'b1, hs, vs, 8'($urandom));
        end
        kill_active = 0;
    endtask

    typedef struct {
        bit r, pe, hs, vs;
        logic [7:0] c;
        int ex, ey;
        bit elk, eer;
    } vec_t;
    vec_t tv[12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hs, vs;
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 0, 0,   1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 0, 0,   1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1, 0,   1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 0, VSB, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 0, VSB, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 1, VSB, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 2, VSB, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 2, VSB, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 3, VSB, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'haa, 0, VSB, 1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hbb, 0, 0,   1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hcc, 1, 0,   1'b0, 1'b0};

        lk_prev = 0; kill_active = 0; lock_pending = 0; n_err = 0;
        model_reset(); tally_reset();

        for (int i = 0; i < 12; i++) begin
            rst = tv[i].r; vif.pix_en_i = tv[i].pe; vif.hs_i = tv[i].hs;
            vif.vs_i = tv[i].vs; vif.col_i = tv[i].c;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 64'({x, y, lk, er, de, colo, fs}),
                  64'({11'(tv[i].ex), 10'(tv[i].ey), tv[i].elk, tv[i].eer, 1'b0, 8'h00, 1'b0}));
        end

        // Nominal stream from reset: lock after the third vs edge.
        g_c = 0; g_l = 0; g_len = H;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        lk_prev = 0; lock_pending = 1; n_err = 0;
        run(4 * H * V, 0);
`ifdef VGA_SYNC_RX_STATS_EN
        check("h_meas", 64'(hm), 64'(H));
        check("v_meas", 64'(vm), 64'(V));
        check("err_cnt_nominal", 64'(ec), 64'(0));
`endif

        // One line shortened by a strobe, then relock.
        while (!(g_l == 3 && g_c == 0)) run(1, 0);
        g_len = H - 1;
        run(5 * H * V, 0);
`ifdef VGA_SYNC_RX_STATS_EN
        check("err_cnt_short_line", 64'(ec), 64'(1));
`endif

        // hs lost for three lines: timeout, then relock.
        while (!(g_l == 2 && g_c == 0)) run(1, 0);
        run(3 * H, 3 * H);
        run(4 * H * V, 0);

        // One-clk reset mid-frame, then reacquire.
        while (!(g_l == 4 && g_c == 5)) run(1, 0);
        gen_next(1'b0, hs, vs);
        step(1'b1, 1'b1, hs, vs, 8'($urandom));
        lock_pending = 1;
        run(4 * H * V, 0);

        check("err_pulses", 64'(n_err), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
